// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the matrix-processor phase controller: phase
// encoding, status constants and the DRAM ownership helpers.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    PROCESS  = 2'd2,
    TRANSMIT = 2'd3
  } phase_t;

  localparam logic [1:0] STATUS_IDLE     = 2'd0;
  localparam logic [1:0] STATUS_RECEIVE  = 2'd1;
  localparam logic [1:0] STATUS_PROCESS  = 2'd2;
  localparam logic [1:0] STATUS_TRANSMIT = 2'd3;

  localparam int DROP_CNT_W = 8;

  // The comm link owns the DRAM while bytes move to or from the PC.
  function automatic logic com_owns(phase_t p);
    return (p == RECEIVE) || (p == TRANSMIT);
  endfunction

  // The core owns the DRAM only while it computes.
  function automatic logic core_owns(phase_t p);
    return (p == PROCESS);
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Front-panel switch debouncer: emits a single-cycle go pulse once the
// switch has been sampled high DEBOUNCE times in a row, then stays quiet
// until the switch is seen low again.
module switch_debouncer #(
  parameter int DEBOUNCE = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic go
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt;
  logic          armed;

  // Count consecutive high samples; fire once, re-arm on any low sample.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      armed <= 1'b1;
      go    <= 1'b0;
    end else if (!sw) begin
      cnt   <= '0;
      armed <= 1'b1;
      go    <= 1'b0;
    end else begin
      go <= 1'b0;
      if (armed) begin
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          go    <= 1'b1;
          armed <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/dram_phase_sequencer.sv
// Phase controller for the matrix-multiplication processor. Sequences
// IDLE/RECEIVE/PROCESS/TRANSMIT from three debounced switches, grants the
// single-port data DRAM to the core or the comm link, and holds the core
// in reset outside PROCESS.
// Optional: define DRAM_DROP_CNT_EN to count blocked non-owner writes.
module dram_phase_sequencer
  import proc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = 1023,
  parameter int AW       = 16,
  parameter int DW       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_receive,
  input  logic                  start_process,
  input  logic                  start_transmit,
  input  logic                  end_receiving,
  input  logic                  process_finish,
  input  logic                  end_transmitting,
  input  logic [AW-1:0]         core_addr,
  input  logic [DW-1:0]         core_wdata,
  input  logic                  core_wren,
  input  logic [AW-1:0]         com_addr,
  input  logic [DW-1:0]         com_wdata,
  input  logic                  com_wren,
  output logic [AW-1:0]         dm_addr,
  output logic [DW-1:0]         dm_wdata,
  output logic                  dm_wren,
  output logic                  core_rst,
  output logic [1:0]            status,
  output logic                  loaded,
  output logic                  computed,
  output logic [DROP_CNT_W-1:0] drop_count
);

  phase_t state, state_nxt;
  logic   rx_go, proc_go, tx_go;

  switch_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_rx (
    .clk(clk), .rst(rst), .sw(start_receive),  .go(rx_go));
  switch_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_proc (
    .clk(clk), .rst(rst), .sw(start_process),  .go(proc_go));
  switch_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_tx (
    .clk(clk), .rst(rst), .sw(start_transmit), .go(tx_go));

  // State register; reset forces IDLE asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: go pulses act only in IDLE, end pulses only in their phase.
  // NOTE: state_nxt gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rx_go)                     state_nxt = RECEIVE;
        else if (proc_go && loaded)    state_nxt = PROCESS;
        else if (tx_go && computed)    state_nxt = TRANSMIT;
      end
      RECEIVE:  if (end_receiving)    state_nxt = IDLE;
      PROCESS:  if (process_finish)   state_nxt = IDLE;
      TRANSMIT: if (end_transmitting) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Phase-completion flags; a new load invalidates the previous result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded   <= 1'b0;
      computed <= 1'b0;
    end else if (state == RECEIVE && end_receiving) begin
      loaded   <= 1'b1;
      computed <= 1'b0;
    end else if (state == PROCESS && process_finish) begin
      computed <= 1'b1;
    end
  end

  // DRAM port mux and core reset, decoded from the state register only.
  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_wren  = 1'b0;
    core_rst = 1'b1;
    if (com_owns(state)) begin
      dm_addr  = com_addr;
      dm_wdata = com_wdata;
      dm_wren  = com_wren;
    end else if (core_owns(state)) begin
      dm_addr  = core_addr;
      dm_wdata = core_wdata;
      dm_wren  = core_wren;
      core_rst = 1'b0;
    end
  end

  assign status = state;

`ifdef DRAM_DROP_CNT_EN
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_q;

  // A blocked write is any wren from a requester that does not own the port.
  always_comb begin
    drop = (core_wren && !core_owns(state)) || (com_wren && !com_owns(state));
  end

  // Saturating blocked-write counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        drop_q <= '0;
    else if (drop && (&drop_q) == 1'b0) drop_q <= drop_q + DROP_CNT_W'(1);
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_dram_phase_sequencer.sv
// Self-checking bench for dram_phase_sequencer with DEBOUNCE=16.
module tb_dram_phase_sequencer;
  import proc_ctrl_pkg::*;

  localparam int D  = 16;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_receive = 1'b0, start_process = 1'b0, start_transmit = 1'b0;
  logic          end_receiving = 1'b0, process_finish = 1'b0, end_transmitting = 1'b0;
  logic [AW-1:0] core_addr = '0, com_addr = '0;
  logic [DW-1:0] core_wdata = '0, com_wdata = '0;
  logic          core_wren = 1'b0, com_wren = 1'b0;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_wren, core_rst, loaded, computed;
  logic [1:0]    status;
  logic [7:0]    drop_count;

  dram_phase_sequencer #(.DEBOUNCE(D), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .start_receive(start_receive), .start_process(start_process),
    .start_transmit(start_transmit),
    .end_receiving(end_receiving), .process_finish(process_finish),
    .end_transmitting(end_transmitting),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_wren(core_wren),
    .com_addr(com_addr), .com_wdata(com_wdata), .com_wren(com_wren),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wren(dm_wren),
    .core_rst(core_rst), .status(status), .loaded(loaded),
    .computed(computed), .drop_count(drop_count));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase as an integer 0..3, run lengths of consecutive high switch samples,
  // and the go pulse that is live during the cycle after the D-th sample.
  int m_phase = 0;
  bit m_loaded = 0, m_computed = 0;
  int m_drop = 0;
  int run [3] = '{0, 0, 0};
  bit m_go [3] = '{0, 0, 0};
  bit sw_s [3];
  bit any_drop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_loaded = 0; m_computed = 0; m_drop = 0;
      for (int i = 0; i < 3; i++) begin run[i] = 0; m_go[i] = 0; end
    end else begin
      sw_s[0] = start_receive; sw_s[1] = start_process; sw_s[2] = start_transmit;
      any_drop = (core_wren && m_phase != 2) || (com_wren && !(m_phase == 1 || m_phase == 3));
      if (any_drop && m_drop < 255) m_drop++;
      case (m_phase)
        0: if (m_go[0]) m_phase = 1;
           else if (m_go[1] && m_loaded) m_phase = 2;
           else if (m_go[2] && m_computed) m_phase = 3;
        1: if (end_receiving) begin m_phase = 0; m_loaded = 1; m_computed = 0; end
        2: if (process_finish) begin m_phase = 0; m_computed = 1; end
        3: if (end_transmitting) m_phase = 0;
        default: m_phase = 0;
      endcase
      for (int i = 0; i < 3; i++) begin
        run[i]  = sw_s[i] ? run[i] + 1 : 0;
        m_go[i] = (run[i] == D);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_wren;
  int            e_drop;
  always @(negedge clk) begin
    e_addr = '0; e_wdata = '0; e_wren = 1'b0;
    if (m_phase == 1 || m_phase == 3) begin
      e_addr = com_addr; e_wdata = com_wdata; e_wren = com_wren;
    end else if (m_phase == 2) begin
      e_addr = core_addr; e_wdata = core_wdata; e_wren = core_wren;
    end
`ifdef DRAM_DROP_CNT_EN
    e_drop = m_drop;
`else
    e_drop = 0;
`endif
    check("status",     32'(status),     32'(m_phase));
    check("core_rst",   32'(core_rst),   32'(m_phase != 2));
    check("dm_addr",    32'(dm_addr),    32'(e_addr));
    check("dm_wdata",   32'(dm_wdata),   32'(e_wdata));
    check("dm_wren",    32'(dm_wren),    32'(e_wren));
    check("loaded",     32'(loaded),     32'(m_loaded));
    check("computed",   32'(computed),   32'(m_computed));
    check("drop_count", 32'(drop_count), 32'(e_drop));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input int idx, input logic v);
    case (idx)
      0: start_receive  = v;
      1: start_process  = v;
      default: start_transmit = v;
    endcase
  endtask

  // Hold a switch until the phase change edge, then release it.
  task automatic press(input int idx);
    set_sw(idx, 1'b1);
    tick(D + 1);
    set_sw(idx, 1'b0);
  endtask

  int exp_drop5;

  initial begin
`ifdef DRAM_DROP_CNT_EN
    exp_drop5 = 5;
`else
    exp_drop5 = 0;
`endif
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("reset status",   32'(status),     32'(STATUS_IDLE));
    check("reset core_rst", 32'(core_rst),   32'd1);
    check("reset dm_wren",  32'(dm_wren),    32'd0);
    check("reset flags",    32'({loaded, computed}), 32'd0);
    check("reset drop",     32'(drop_count), 32'd0);

    // Process press without loaded data is ignored.
    start_process = 1'b1;
    tick(2000);
    check("proc unloaded status",   32'(status),   32'd0);
    check("proc unloaded core_rst", 32'(core_rst), 32'd1);
    start_process = 1'b0;
    tick(2);

    // Short receive press does not trigger.
    start_receive = 1'b1;
    tick(10);
    start_receive = 1'b0;
    tick(20);
    check("short press status", 32'(status), 32'd0);

    // Full receive press: status changes exactly at edge D+1.
    start_receive = 1'b1;
    tick(D);
    check("rx edge D status", 32'(status), 32'd0);
    tick(1);
    check("rx edge D+1 status", 32'(status), 32'(STATUS_RECEIVE));
    tick(3);
    start_receive = 1'b0;
    com_addr = 16'h0012; com_wdata = 8'hA5; com_wren = 1'b1;
    #1;
    check("rx dm_addr",  32'(dm_addr),  32'h0012);
    check("rx dm_wdata", 32'(dm_wdata), 32'hA5);
    check("rx dm_wren",  32'(dm_wren),  32'd1);
    tick(1);
    com_wren = 1'b0;
    core_addr = 16'h00F0; core_wdata = 8'h11; core_wren = 1'b1;
    tick(2);
    check("rx core blocked", 32'(dm_wren), 32'd0);
    tick(3);
    core_wren = 1'b0;
    check("rx drop count", 32'(drop_count), 32'(exp_drop5));
    end_receiving = 1'b1;
    tick(1);
    end_receiving = 1'b0;
    check("end rx status", 32'(status), 32'd0);
    check("end rx loaded", 32'(loaded), 32'd1);
    tick(2);

    // Simultaneous receive and process presses: receive wins.
    start_receive = 1'b1; start_process = 1'b1;
    tick(D + 1);
    start_receive = 1'b0; start_process = 1'b0;
    check("priority status", 32'(status), 32'(STATUS_RECEIVE));
    tick(2);

    // Process go coinciding with end_receiving is dropped.
    start_process = 1'b1;
    tick(D);
    end_receiving = 1'b1;
    tick(1);
    end_receiving = 1'b0;
    check("coincide end status", 32'(status), 32'd0);
    tick(3);
    check("coincide go dropped", 32'(status), 32'd0);
    start_process = 1'b0;
    tick(2);

    // Process phase: core released and owning the port.
    press(1);
    check("proc status",   32'(status),   32'(STATUS_PROCESS));
    check("proc core_rst", 32'(core_rst), 32'd0);
    core_addr = 16'h1234; core_wdata = 8'h3C; core_wren = 1'b1;
    com_addr = 16'h0055; com_wdata = 8'h77; com_wren = 1'b1;
    #1;
    check("proc dm_addr",  32'(dm_addr),  32'h1234);
    check("proc dm_wdata", 32'(dm_wdata), 32'h3C);
    check("proc dm_wren",  32'(dm_wren),  32'd1);
    tick(2);
    core_wren = 1'b0; com_wren = 1'b0;
    process_finish = 1'b1;
    tick(1);
    process_finish = 1'b0;
    check("fin status",   32'(status),   32'd0);
    check("fin core_rst", 32'(core_rst), 32'd1);
    check("fin computed", 32'(computed), 32'd1);
    tick(2);

    // Two transmit phases back to back.
    for (int k = 0; k < 2; k++) begin
      press(2);
      check("tx status", 32'(status), 32'(STATUS_TRANSMIT));
      tick(3);
      end_transmitting = 1'b1;
      tick(1);
      end_transmitting = 1'b0;
      check("tx end status",   32'(status),   32'd0);
      check("tx end computed", 32'(computed), 32'd1);
      tick(2);
    end

    // New receive invalidates the result.
    press(0);
    check("rx2 status", 32'(status), 32'(STATUS_RECEIVE));
    tick(2);
    end_receiving = 1'b1;
    tick(1);
    end_receiving = 1'b0;
    check("rx2 computed", 32'(computed), 32'd0);
    check("rx2 loaded",   32'(loaded),   32'd1);
    tick(2);

    // Asynchronous reset in the middle of PROCESS.
    press(1);
    check("proc2 status", 32'(status), 32'(STATUS_PROCESS));
    core_wren = 1'b1;
    tick(1);
    #2 rst = 1'b1;
    #1;
    check("async core_rst", 32'(core_rst), 32'd1);
    check("async dm_wren",  32'(dm_wren),  32'd0);
    check("async status",   32'(status),   32'd0);
    check("async flags",    32'({loaded, computed}), 32'd0);
    core_wren = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
